// File: rtl/debounce_bank.sv
// Multi-channel switch conditioner: per-channel synchroniser, consecutive-sample
// debounce, one-clock rise/fall strobes and keyboard-style auto-repeat press strobes.
module debounce_bank #(
  parameter int CHANNELS     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_COUNT    = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clken,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press,
  output logic                any_event
);

  localparam int CNT_W  = $clog2(MAX_COUNT);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_COUNT - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic [RCNT_W-1:0]      rcnt_reg, rcnt_next;
      rep_state_t             state_reg, state_next;
      logic                   out_reg, out_next;
      logic                   rise_reg, fall_reg;
      logic                   press_reg, press_next;
      logic                   sample, differ, commit, commit_rise, commit_fall;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
        end
      end

      assign sample      = sync_reg[SYNC_STAGES-1];
      assign differ      = sample ^ out_reg;
      assign commit      = clken && differ && (cnt_reg == CNT_LAST);
      assign commit_rise = commit & sample;
      assign commit_fall = commit & ~sample;

      // Any agreeing sample restarts the run of differing ticks.
      always_comb begin
        cnt_next = cnt_reg;
        out_next = out_reg;
        if (clken) begin
          if (!differ) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            out_next = sample;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      // Press fires on every committed rise; repeats only while held and enabled.
      // A fall or a dropped enable returns to idle before any pending expiry.
      always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        press_next = commit_rise;
        case (state_reg)
          ST_IDLE: begin
            if (commit_rise && repeat_en[gi]) begin
              state_next = ST_DELAY;
              rcnt_next  = '0;
            end
          end
          ST_DELAY: begin
            if (commit_fall || !repeat_en[gi]) begin
              state_next = ST_IDLE;
              rcnt_next  = '0;
            end else if (clken) begin
              if (rcnt_reg == DELAY_LAST) begin
                press_next = 1'b1;
                rcnt_next  = '0;
                state_next = ST_REPEAT;
              end else begin
                rcnt_next = rcnt_reg + RCNT_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (commit_fall || !repeat_en[gi]) begin
              state_next = ST_IDLE;
              rcnt_next  = '0;
            end else if (clken) begin
              if (rcnt_reg == RATE_LAST) begin
                press_next = 1'b1;
                rcnt_next  = '0;
              end else begin
                rcnt_next = rcnt_reg + RCNT_W'(1);
              end
            end
          end
          default: begin
            state_next = ST_IDLE;
            rcnt_next  = '0;
          end
        endcase
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_reg   <= '0;
          out_reg   <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          press_reg <= 1'b0;
          rcnt_reg  <= '0;
          state_reg <= ST_IDLE;
        end else begin
          cnt_reg   <= cnt_next;
          out_reg   <= out_next;
          rise_reg  <= commit_rise;
          fall_reg  <= commit_fall;
          press_reg <= press_next;
          rcnt_reg  <= rcnt_next;
          state_reg <= state_next;
        end
      end

      assign out[gi]   = out_reg;
      assign rise[gi]  = rise_reg;
      assign fall[gi]  = fall_reg;
      assign press[gi] = press_reg;
    end
  endgenerate

  assign any_event = |(rise | fall | press);

endmodule
